// File: rtl/unet_fsm_3_1_core.sv
// UNet stage 3_1 controller: loads weights and a frame, computes a 16-channel
// 1x1 convolution with ReLU/saturation to int8, then streams the feature map out.
module unet_fsm_3_1_core #(
    parameter int N_WEIGHTS = 1680,
    parameter int N_DATA    = 49218,
    parameter int N_OUT     = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        unet_enpulse,
    input  logic [31:0] data_in,
    output logic [2:0]  ctrl,
    output logic        busy,
    output logic [31:0] data_out
);

    typedef enum logic [2:0] {
        ST_CALC   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_D = 3'd2,
        ST_READY  = 3'd3,
        ST_SEND   = 3'd4,
        ST_IDLE   = 3'd5
    } state_t;

    localparam int N_PIX   = N_OUT / 4;
    localparam int PIX_W   = $clog2(N_PIX);
    localparam int OUT_W   = $clog2(N_OUT);
    localparam int IDX_MAX = (N_DATA > N_OUT + 1) ? N_DATA : N_OUT + 1;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic               w_loaded_r, w_loaded_s;
    logic [4:0]         sh_r, sh_s;
    logic               busy_r, busy_s;
    logic [31:0]        data_out_r, data_out_s;
    logic               w_we_s, pix_we_s, out_we_s;
    logic [PIX_W-1:0]   pix_waddr_s, pix_raddr_s;
    logic [OUT_W-1:0]   out_addr_s;
    logic [31:0]        pix_s, calc_word_s;

    logic [31:0] w_mem_r   [32];
    logic [31:0] pix_mem_r [N_PIX];
    logic [31:0] out_mem_r [N_OUT];

    // One output lane: bias plus 4-tap int8 dot product, arithmetic shift, clamp to [0,127].
    function automatic logic [7:0] lane_q(input logic [31:0] pix, input logic [31:0] wrow,
                                          input logic [31:0] bias, input logic [4:0] sh);
        logic signed [31:0] acc;
        logic signed [31:0] r;
        acc = signed'(bias);
        for (int k = 0; k < 4; k++) begin
            acc = acc + 32'(signed'(pix[8*k +: 8])) * 32'(signed'(wrow[8*k +: 8]));
        end
        r = acc >>> sh;
        if (r < 32'sd0) begin
            return 8'd0;
        end else if (r > 32'sd127) begin
            return 8'd127;
        end else begin
            return r[7:0];
        end
    endfunction

    assign pix_waddr_s = PIX_W'(idx_r - IDX_W'(1));
    assign pix_raddr_s = idx_r[OUT_W-1:2];
    assign out_addr_s  = idx_r[OUT_W-1:0];
    assign pix_s       = pix_mem_r[pix_raddr_s];

    // Output word for index o: group g = o[1:0] selects channels 4g..4g+3.
    always_comb begin
        calc_word_s = 32'd0;
        for (int j = 0; j < 4; j++) begin
            calc_word_s[8*j +: 8] = lane_q(pix_s,
                                           w_mem_r[{1'b0, idx_r[1:0], 2'(j)}],
                                           w_mem_r[{1'b1, idx_r[1:0], 2'(j)}],
                                           sh_r);
        end
    end

    // Next-state, index and output-word decode.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        w_loaded_s = w_loaded_r;
        sh_s       = sh_r;
        data_out_s = 32'd0;
        w_we_s     = 1'b0;
        pix_we_s   = 1'b0;
        out_we_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (unet_enpulse) begin
                    state_s = w_loaded_r ? ST_LOAD_D : ST_LOAD_W;
                    idx_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD_W: begin
                w_we_s = (idx_r < IDX_W'(32));
                if (idx_r == IDX_W'(N_WEIGHTS - 1)) begin
                    w_loaded_s = 1'b1;
                    state_s    = ST_IDLE;
                    idx_s      = '0;
                end else begin
                    idx_s = idx_r + IDX_W'(1);
                end
            end
            ST_LOAD_D: begin
                if (idx_r == '0) begin
                    sh_s = data_in[4:0];
                end else begin
                    sh_s = sh_r;
                end
                pix_we_s = (idx_r != '0) && (idx_r <= IDX_W'(N_PIX));
                if (idx_r == IDX_W'(N_DATA - 1)) begin
                    state_s = ST_CALC;
                    idx_s   = '0;
                end else begin
                    idx_s = idx_r + IDX_W'(1);
                end
            end
            ST_CALC: begin
                out_we_s = 1'b1;
                if (idx_r == IDX_W'(N_OUT - 1)) begin
                    state_s = ST_READY;
                    idx_s   = '0;
                end else begin
                    idx_s = idx_r + IDX_W'(1);
                end
            end
            ST_READY: begin
                if (unet_enpulse) begin
                    state_s    = ST_SEND;
                    data_out_s = out_mem_r[{OUT_W{1'b0}}];
                    idx_s      = IDX_W'(1);
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_SEND: begin
                // idx runs one past N_OUT so the trailing zero word gets its own cycle
                if (idx_r < IDX_W'(N_OUT)) begin
                    data_out_s = out_mem_r[out_addr_s];
                    idx_s      = idx_r + IDX_W'(1);
                end else if (idx_r == IDX_W'(N_OUT)) begin
                    data_out_s = 32'd0;
                    idx_s      = idx_r + IDX_W'(1);
                end else begin
                    state_s = ST_IDLE;
                    idx_s   = '0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = '0;
            end
        endcase
    end

    assign busy_s = (state_s == ST_CALC) || (state_s == ST_LOAD_W) ||
                    (state_s == ST_LOAD_D) || (state_s == ST_SEND);

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            w_loaded_r <= 1'b0;
            sh_r       <= 5'd0;
            busy_r     <= 1'b0;
            data_out_r <= 32'd0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            w_loaded_r <= w_loaded_s;
            sh_r       <= sh_s;
            busy_r     <= busy_s;
            data_out_r <= data_out_s;
        end
    end

    // Buffer writes; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_we_s) begin
            w_mem_r[idx_r[4:0]] <= data_in;
        end
        if (pix_we_s) begin
            pix_mem_r[pix_waddr_s] <= data_in;
        end
        if (out_we_s) begin
            out_mem_r[out_addr_s] <= calc_word_s;
        end
    end

    assign ctrl     = state_r;
    assign busy     = busy_r;
    assign data_out = data_out_r;

endmodule

// File: tb/tb_unet_fsm_3_1_core.sv
// Scoreboard bench for unet_fsm_3_1_core on a reduced frame (64 pixels, 256 output words).
module tb_unet_fsm_3_1_core;

    localparam int NW = 40;
    localparam int ND = 80;
    localparam int NO = 256;
    localparam int NP = NO / 4;

    logic        clk;
    logic        rst_n;
    logic        unet_enpulse;
    logic [31:0] data_in;
    logic [2:0]  ctrl;
    logic        busy;
    logic [31:0] data_out;

    logic [31:0] wbuf  [NW];
    logic [31:0] dbuf  [ND];
    logic [31:0] exp_w [NO];
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    int          n_vec;
    int          n_err;

    unet_fsm_3_1_core #(.N_WEIGHTS(NW), .N_DATA(ND), .N_OUT(NO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .unet_enpulse (unet_enpulse),
        .data_in      (data_in),
        .ctrl         (ctrl),
        .busy         (busy),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT shows ctrl=4, data_out must match the queue head.
    always @(negedge clk) begin
        if (ctrl == 3'd4) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL send_extra: got 0x%08h with empty scoreboard", data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (data_out !== mon_exp) begin
                    n_err++;
                    $display("FAIL send_word: got 0x%08h expected 0x%08h", data_out, mon_exp);
                end
            end
        end
    end

    task automatic fill_weights(input int kind);
        for (int i = 0; i < NW; i++) wbuf[i] = 32'hDEAD0000 | 32'(i);
        for (int c = 0; c < 16; c++) begin
            case (kind)
                0: begin wbuf[c] = 32'd1 << (8 * (c % 4)); wbuf[16+c] = 32'd0; end
                1: begin wbuf[c] = 32'h7F7F7F7F; wbuf[16+c] = 32'(c); end
                default: begin
                    wbuf[c] = 32'd0;
                    wbuf[16+c] = (c % 2 == 0) ? 32'(5 * c) : 32'hFFFFFC18;
                end
            endcase
        end
    endtask

    task automatic fill_data(input int kind, input logic [4:0] sh);
        dbuf[0] = {27'h5555555, sh};
        for (int p = 0; p < NP; p++) begin
            case (kind)
                0: dbuf[1+p] = 32'h05FB0A7F;
                1: dbuf[1+p] = {8'hFF, 8'(p), 8'h80, 8'(2 * p)};
                default: dbuf[1+p] = 32'h7F7F7F7F;
            endcase
        end
        for (int i = 1 + NP; i < ND; i++) dbuf[i] = 32'hFFFFFFFF;
    endtask

    task automatic do_reset(input logic with_pulse);
        @(negedge clk);
        rst_n = 1'b1;
        unet_enpulse = with_pulse;
        @(negedge clk);
        rst_n = 1'b0;
        unet_enpulse = 1'b0;
        exp_q.delete();
        check("reset_ctrl", 32'(ctrl), 32'd5);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dout", data_out, 32'd0);
    endtask

    task automatic stream(input logic [2:0] code, input int n, input logic is_w);
        int cnt;
        @(negedge clk);
        unet_enpulse = 1'b1;
        data_in = is_w ? wbuf[0] : dbuf[0];
        @(negedge clk);
        unet_enpulse = 1'b0;
        check("load_entry", 32'(ctrl), 32'(code));
        check("load_busy", 32'(busy), 32'd1);
        cnt = 0;
        while (ctrl == code && cnt < n + 8) begin
            if (cnt < n) data_in = is_w ? wbuf[cnt] : dbuf[cnt];
            cnt++;
            @(negedge clk);
        end
        check("load_len", 32'(cnt), 32'(n));
    endtask

    task automatic run_calc();
        int cnt;
        check("calc_entry", 32'(ctrl), 32'd0);
        cnt = 0;
        while (ctrl == 3'd0 && cnt < NO + 8) begin
            unet_enpulse = (cnt == 5);
            cnt++;
            @(negedge clk);
        end
        unet_enpulse = 1'b0;
        check("calc_len", 32'(cnt), 32'(NO));
        check("ready_ctrl", 32'(ctrl), 32'd3);
        check("ready_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_send(input int stop_at);
        int cnt;
        repeat (2) @(negedge clk);
        check("ready_hold", 32'(ctrl), 32'd3);
        for (int o = 0; o < NO; o++) exp_q.push_back(exp_w[o]);
        exp_q.push_back(32'd0);
        unet_enpulse = 1'b1;
        @(negedge clk);
        unet_enpulse = 1'b0;
        cnt = 0;
        while (ctrl == 3'd4 && cnt < NO + 10) begin
            if (stop_at != 0 && cnt == stop_at) break;
            unet_enpulse = (cnt == 7);
            cnt++;
            @(negedge clk);
        end
        unet_enpulse = 1'b0;
        if (stop_at == 0) begin
            check("send_len", 32'(cnt), 32'(NO + 1));
            check("post_send_ctrl", 32'(ctrl), 32'd5);
            check("post_send_dout", data_out, 32'd0);
            check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        unet_enpulse = 1'b0;
        data_in = 32'd0;
        repeat (3) @(negedge clk);
        do_reset(1'b0);

        // Frame 1: identity weights, lane j echoes input channel j clamped to 0..127
        fill_weights(0);
        stream(3'd1, NW, 1'b1);
        check("after_wload", 32'(ctrl), 32'd5);
        fill_data(0, 5'd0);
        for (int o = 0; o < NO; o++) exp_w[o] = 32'h05000A7F;
        stream(3'd2, ND, 1'b0);
        run_calc();
        run_send(0);

        // Frame 2: same weights, new pixels and shift 1
        fill_data(1, 5'd1);
        for (int o = 0; o < NO; o++) exp_w[o] = {8'h00, 8'((o / 4) >> 1), 8'h00, 8'(o / 4)};
        stream(3'd2, ND, 1'b0);
        run_calc();
        run_send(0);

        // Frame 3: saturating weights
        do_reset(1'b0);
        fill_weights(1);
        stream(3'd1, NW, 1'b1);
        fill_data(2, 5'd2);
        for (int o = 0; o < NO; o++) exp_w[o] = 32'h7F7F7F7F;
        stream(3'd2, ND, 1'b0);
        run_calc();
        run_send(0);

        // Frame 4: zero weights, bias-only channels (odd channels negative)
        do_reset(1'b0);
        fill_weights(2);
        stream(3'd1, NW, 1'b1);
        fill_data(2, 5'd0);
        for (int o = 0; o < NO; o++)
            exp_w[o] = {8'h00, 8'(5 * (4 * (o % 4) + 2)), 8'h00, 8'(20 * (o % 4))};
        stream(3'd2, ND, 1'b0);
        run_calc();
        run_send(0);

        // Frame 5: reset mid-send with a coincident pulse, then weights must reload
        fill_data(0, 5'd0);
        stream(3'd2, ND, 1'b0);
        run_calc();
        run_send(20);
        do_reset(1'b1);
        stream(3'd1, NW, 1'b1);
        check("reload_done", 32'(ctrl), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
